// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg
// Shared encodings for the multicycle ARM control unit: FSM state type,
// ALUControl codes, ResultSrc/ALUSrcB mux encodings, instruction field codes
// and the ARM condition-code table.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_UNKNOWN
    } statetype;

    // ALUControl
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Op field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing cmd field (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/arm_cond_logic.sv
// arm_cond_logic
// Holds the NZCV flags register and evaluates the instruction condition.
// Ports:
//   clk, reset  clock and synchronous active-high reset (flags cleared)
//   Cond        instruction condition field
//   ALUFlags    NZCV produced by the ALU this cycle
//   FlagW       [1] = update NZ, [0] = update CV
//   FlagEn      high in the cycle whose ALU result may update the flags
//   CondEx      condition passes against the registered flags
module arm_cond_logic
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       FlagEn,
    output logic       CondEx
);

    // flag_pair_q[1] = {N,Z}, flag_pair_q[0] = {C,V}; each pair has its own enable.
    logic [1:0] flag_pair_q [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flag_pair
            always_ff @(posedge clk) begin
                if (reset) begin
                    flag_pair_q[gi] <= 2'b00;
                end else if (FlagEn && FlagW[gi] && CondEx) begin
                    flag_pair_q[gi] <= ALUFlags[2*gi+1 -: 2];
                end
            end
        end
    endgenerate

    logic n_flag, z_flag, c_flag, v_flag;
    assign n_flag = flag_pair_q[1][1];
    assign z_flag = flag_pair_q[1][0];
    assign c_flag = flag_pair_q[0][1];
    assign v_flag = flag_pair_q[0][0];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z_flag;
            COND_NE: CondEx = ~z_flag;
            COND_CS: CondEx = c_flag;
            COND_CC: CondEx = ~c_flag;
            COND_MI: CondEx = n_flag;
            COND_PL: CondEx = ~n_flag;
            COND_VS: CondEx = v_flag;
            COND_VC: CondEx = ~v_flag;
            COND_HI: CondEx = c_flag & ~z_flag;
            COND_LS: CondEx = ~c_flag | z_flag;
            COND_GE: CondEx = (n_flag == v_flag);
            COND_LT: CondEx = (n_flag != v_flag);
            COND_GT: CondEx = ~z_flag & (n_flag == v_flag);
            COND_LE: CondEx = z_flag | (n_flag != v_flag);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;   // 1111 never executes
        endcase
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl
// Control unit for the multicycle ARM datapath: FSM sequencing, ALU decode,
// conditional execution, PC write logic and a retired-instruction counter.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   Instr        IR[31:12] = {Cond, Op, Funct, Rn, Rd}
//   ALUFlags     NZCV from the ALU this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//   ALUSrcB, ImmSrc, RegSrc, ALUControl   datapath controls
//   Retired      pulse on the last cycle of each instruction
//   InstrCount   wrapping count of Retired pulses
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [19:0]      Instr,
    input  logic [3:0]       ALUFlags,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic [1:0]       ALUControl,
    output logic             Retired,
    output logic [CNT_W-1:0] InstrCount
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    statetype state_q, state_d;

    // ALU decoder
    logic [1:0] alu_dec;
    logic       no_write;
    logic       arith;
    logic [1:0] flag_w;

    always_comb begin
        alu_dec  = ALU_ADD;
        no_write = 1'b0;
        arith    = 1'b0;
        case (funct[4:1])
            CMD_ADD: begin alu_dec = ALU_ADD; arith = 1'b1; end
            CMD_SUB: begin alu_dec = ALU_SUB; arith = 1'b1; end
            CMD_AND: alu_dec = ALU_AND;
            CMD_ORR: alu_dec = ALU_ORR;
            CMD_CMP: begin alu_dec = ALU_SUB; arith = 1'b1; no_write = 1'b1; end
            default: begin alu_dec = ALU_ADD; no_write = 1'b1; end
        endcase
        flag_w = {funct[0], funct[0] & arith};
    end

    logic flag_en;
    logic cond_ex;
    logic cond_ex_q;

    arm_cond_logic u_cond (
        .clk      (clk),
        .reset    (reset),
        .Cond     (cond),
        .ALUFlags (ALUFlags),
        .FlagW    (flag_w),
        .FlagEn   (flag_en),
        .CondEx   (cond_ex)
    );

    // A flag-setting conditional instruction (e.g. SUBNES) can change the
    // flags at the end of EXECUTE; its writeback must still follow the
    // condition as evaluated before execution, so ALUWB uses this copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_ex_q <= 1'b0;
        end else if (flag_en) begin
            cond_ex_q <= cond_ex;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    logic pcw_raw, memw_raw, irw_raw, regw_raw, retire_raw;

    always_comb begin
        state_d    = state_q;
        pcw_raw    = 1'b0;
        memw_raw   = 1'b0;
        irw_raw    = 1'b0;
        regw_raw   = 1'b0;
        retire_raw = 1'b0;
        flag_en    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_WD;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                irw_raw   = 1'b1;
                pcw_raw   = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                regw_raw   = cond_ex;
                retire_raw = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                memw_raw   = cond_ex;
                retire_raw = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcB    = SRCB_WD;
                ALUControl = alu_dec;
                flag_en    = 1'b1;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_dec;
                flag_en    = 1'b1;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                regw_raw   = cond_ex_q & ~no_write;
                retire_raw = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                pcw_raw    = cond_ex;
                retire_raw = 1'b1;
                state_d    = S_FETCH;
            end
            S_UNKNOWN: begin
                retire_raw = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Writing R15 from ALUWB/MEMWB redirects the PC in the same cycle.
    // Enables are masked during reset so an interrupted instruction has no effect.
    assign PCWrite  = ~reset & (pcw_raw | (regw_raw & (rd == 4'hF)));
    assign MemWrite = ~reset & memw_raw;
    assign IRWrite  = ~reset & irw_raw;
    assign RegWrite = ~reset & regw_raw;
    assign Retired  = ~reset & retire_raw;

    assign ImmSrc = op;
    assign RegSrc = {op == OP_MEM, op == OP_BR};

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (Retired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign InstrCount = count_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
module tb_arm_multicycle_ctrl;

    localparam int CNT_W = 8;   // small width so the random run exercises the wrap

    logic             clk = 1'b0;
    logic             reset;
    logic [19:0]      Instr;
    logic [3:0]       ALUFlags;
    logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Retired;
    logic [1:0]       ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [CNT_W-1:0] InstrCount;

    arm_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Retired    (Retired),
        .InstrCount (InstrCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] rsrc;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] imm;
        logic [1:0] rsel;
        logic [1:0] aluc;
        logic       ret;
    } ov_t;

    ov_t obs;
    always_comb obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                       ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Retired};

    int vectors = 0;
    int miscompares = 0;

    // Architectural reference state
    logic [3:0]       m_flags;   // NZCV
    logic [CNT_W-1:0] m_count;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // cmd -> (ALU op, suppress writeback, updates CV)
    function automatic void alu_model(input logic [3:0] cmd, output logic [1:0] ctl,
                                      output logic nw, output logic ar);
        case (cmd)
            4'b0100: begin ctl = 2'b00; nw = 1'b0; ar = 1'b1; end
            4'b0010: begin ctl = 2'b01; nw = 1'b0; ar = 1'b1; end
            4'b0000: begin ctl = 2'b10; nw = 1'b0; ar = 1'b0; end
            4'b1100: begin ctl = 2'b11; nw = 1'b0; ar = 1'b0; end
            4'b1010: begin ctl = 2'b01; nw = 1'b1; ar = 1'b1; end
            default: begin ctl = 2'b00; nw = 1'b1; ar = 1'b0; end
        endcase
    endfunction

    // Runs one instruction (or its first max_cyc cycles) and compares every cycle
    // against the expected control vector for that instruction class.
    task automatic run_instr(input logic [31:0] ins, input int af_force, input int max_cyc,
                             output ov_t last_o);
        logic [3:0] c;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic       pass, nw, ar, is_dp, is_ldr, is_str, is_b;
        logic [1:0] ctl;
        logic [3:0] af;
        int         ncyc;
        ov_t        e, m;
        c      = ins[31:28];
        op     = ins[27:26];
        funct  = ins[25:20];
        rd     = ins[15:12];
        is_dp  = (op == 2'b00);
        is_ldr = (op == 2'b01) && funct[0];
        is_str = (op == 2'b01) && !funct[0];
        is_b   = (op == 2'b10);
        ncyc   = is_ldr ? 5 : (is_dp || is_str) ? 4 : 3;
        pass   = cond_pass(c, m_flags);
        alu_model(funct[4:1], ctl, nw, ar);
        last_o = '0;
        for (int k = 0; k < ncyc && k < max_cyc; k++) begin
            af       = (af_force < 0) ? 4'($urandom) : 4'(af_force);
            Instr    = ins[31:12];
            ALUFlags = af;
            e = '0;
            m = '0;
            e.imm  = op;
            e.rsel = {op == 2'b01, op == 2'b10};
            m.imm = '1; m.rsel = '1; m.pcw = 1'b1; m.irw = 1'b1; m.memw = 1'b1;
            m.regw = 1'b1; m.ret = 1'b1; m.aluc = '1;
            if (k == 0) begin
                e.asa = 1'b1; e.asb = 2'b10; e.rsrc = 2'b10; e.irw = 1'b1; e.pcw = 1'b1;
                m.adr = 1'b1; m.asa = 1'b1; m.asb = '1; m.rsrc = '1;
            end else if (k == 1) begin
                e.asa = 1'b1; e.asb = 2'b10; e.rsrc = 2'b10;
                m.asa = 1'b1; m.asb = '1; m.rsrc = '1;
            end else if (k == 2) begin
                if (is_dp) begin
                    e.asb  = funct[5] ? 2'b01 : 2'b00;
                    e.aluc = ctl;
                    m.asa = 1'b1; m.asb = '1;
                end else if (is_ldr || is_str) begin
                    e.asb = 2'b01;
                    m.asa = 1'b1; m.asb = '1;
                end else if (is_b) begin
                    e.asb = 2'b01; e.rsrc = 2'b10; e.pcw = pass; e.ret = 1'b1;
                    m.asa = 1'b1; m.asb = '1; m.rsrc = '1;
                end else begin
                    e.ret = 1'b1;
                end
            end else if (k == 3) begin
                if (is_dp) begin
                    e.regw = pass && !nw;
                    e.pcw  = e.regw && (rd == 4'hF);
                    e.ret  = 1'b1;
                    m.rsrc = '1;
                end else begin
                    e.adr  = 1'b1;
                    e.memw = is_str && pass;
                    e.ret  = is_str;
                    m.adr  = 1'b1;
                end
            end else begin
                e.rsrc = 2'b01; e.regw = pass; e.pcw = pass && (rd == 4'hF); e.ret = 1'b1;
                m.rsrc = '1;
            end
            @(negedge clk);
            vectors++;
            if ((obs & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL ctrl_vec ins=%h cycle=%0d got=%h expected=%h care=%h",
                         ins, k + 1, obs & m, e & m, m);
            end
            vectors++;
            if (InstrCount !== m_count) begin
                miscompares++;
                $display("FAIL instr_count ins=%h cycle=%0d got=%0d expected=%0d",
                         ins, k + 1, InstrCount, m_count);
            end
            if (is_dp && k == 2 && pass && funct[0]) begin
                m_flags[3:2] = af[3:2];
                if (ar) m_flags[1:0] = af[1:0];
            end
            if (e.ret) m_count = m_count + 1'b1;
            last_o = obs;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset    = 1'b1;
            Instr    = 20'($urandom);
            ALUFlags = 4'($urandom);
            @(negedge clk);
            vectors++;
            if ({PCWrite, MemWrite, IRWrite, RegWrite, Retired} !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_enables cycle=%0d got=%b expected=00000", i,
                         {PCWrite, MemWrite, IRWrite, RegWrite, Retired});
            end
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        m_flags = 4'b0;
        m_count = '0;
    endtask

    task automatic test_reset();
        do_reset(3);
        vectors++;
        if (InstrCount !== '0) begin
            miscompares++;
            $display("FAIL reset_count got=%0d expected=0", InstrCount);
        end
    endtask

    task automatic test_add_imm();
        ov_t lo;
        logic [CNT_W-1:0] c0;
        c0 = m_count;
        run_instr(32'hE2802005, -1, 99, lo);
        vectors++;
        if (lo.regw !== 1'b1 || lo.ret !== 1'b1 || InstrCount !== CNT_W'(c0 + 1)) begin
            miscompares++;
            $display("FAIL add_imm got regw=%b ret=%b count=%0d expected regw=1 ret=1 count=%0d",
                     lo.regw, lo.ret, InstrCount, CNT_W'(c0 + 1));
        end
    endtask

    task automatic test_mem();
        ov_t lo;
        run_instr(32'hE5837054, -1, 99, lo);
        vectors++;
        if (lo.memw !== 1'b1 || lo.adr !== 1'b1) begin
            miscompares++;
            $display("FAIL str got memw=%b adr=%b expected memw=1 adr=1", lo.memw, lo.adr);
        end
        run_instr(32'hE5932000, -1, 99, lo);
        vectors++;
        if (lo.regw !== 1'b1 || lo.rsrc !== 2'b01) begin
            miscompares++;
            $display("FAIL ldr got regw=%b rsrc=%b expected regw=1 rsrc=01", lo.regw, lo.rsrc);
        end
    endtask

    task automatic test_branch();
        ov_t lo;
        run_instr(32'hE0577007, 4'b0100, 99, lo);   // SUBS: Z=1
        run_instr(32'h0A000001, -1, 99, lo);         // BEQ taken
        vectors++;
        if (lo.pcw !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_taken got pcw=%b expected 1", lo.pcw);
        end
        run_instr(32'hE0577007, 4'b0000, 99, lo);   // SUBS: Z=0
        run_instr(32'h0A000001, -1, 99, lo);         // BEQ not taken
        vectors++;
        if (lo.pcw !== 1'b0 || lo.ret !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_not_taken got pcw=%b ret=%b expected pcw=0 ret=1", lo.pcw, lo.ret);
        end
    endtask

    task automatic test_cond();
        ov_t lo;
        run_instr(32'hE0577007, 4'b0100, 99, lo);   // Z=1
        run_instr(32'h12802005, -1, 99, lo);         // ADDNE skipped
        vectors++;
        if (lo.regw !== 1'b0) begin
            miscompares++;
            $display("FAIL addne_skip got regw=%b expected 0", lo.regw);
        end
        run_instr(32'h0A000001, -1, 99, lo);         // Z still 1
        vectors++;
        if (lo.pcw !== 1'b1) begin
            miscompares++;
            $display("FAIL flags_kept got pcw=%b expected 1", lo.pcw);
        end
        run_instr(32'hE1570007, 4'b0000, 99, lo);   // CMP clears Z
        vectors++;
        if (lo.regw !== 1'b0) begin
            miscompares++;
            $display("FAIL cmp_nowrite got regw=%b expected 0", lo.regw);
        end
        run_instr(32'h0A000001, -1, 99, lo);
        vectors++;
        if (lo.pcw !== 1'b0) begin
            miscompares++;
            $display("FAIL cmp_flags got pcw=%b expected 0", lo.pcw);
        end
    endtask

    task automatic test_unknown();
        ov_t lo;
        run_instr(32'hEC000000, -1, 99, lo);
        vectors++;
        if ({lo.pcw, lo.memw, lo.irw, lo.regw, lo.ret} !== 5'b00001) begin
            miscompares++;
            $display("FAIL unknown got=%b expected=00001",
                     {lo.pcw, lo.memw, lo.irw, lo.regw, lo.ret});
        end
        run_instr(32'hE2802005, -1, 99, lo);
    endtask

    task automatic test_reset_mid();
        ov_t lo;
        run_instr(32'hE5932000, -1, 2, lo);    // LDR interrupted after DECODE
        do_reset(3);
        vectors++;
        if (InstrCount !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_count got=%0d expected=0", InstrCount);
        end
        run_instr(32'hE2802005, -1, 99, lo);
        run_instr(32'hE5837054, -1, 3, lo);    // STR up to MEMADR
        do_reset(1);                           // lands on MEMWR
        vectors++;
        if (InstrCount !== '0) begin
            miscompares++;
            $display("FAIL reset_memwr_count got=%0d expected=0", InstrCount);
        end
        run_instr(32'hE5837054, -1, 99, lo);
    endtask

    task automatic test_random(input int n);
        ov_t        lo;
        logic [3:0] c, rd, cmd;
        logic [1:0] op;
        logic [5:0] funct;
        for (int i = 0; i < n; i++) begin
            c     = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            op    = 2'($urandom_range(0, 3));
            funct = 6'($urandom);
            if (op == 2'b00) begin
                case ($urandom_range(0, 5))
                    0: cmd = 4'b0100;
                    1: cmd = 4'b0010;
                    2: cmd = 4'b0000;
                    3: cmd = 4'b1100;
                    4: cmd = 4'b1010;
                    default: cmd = 4'($urandom);
                endcase
                funct[4:1] = cmd;
            end
            rd = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            run_instr({c, op, funct, 4'($urandom), rd, 12'($urandom)}, -1, 99, lo);
        end
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = '0;
        ALUFlags = '0;
        m_flags  = '0;
        m_count  = '0;
        #1;
        test_reset();
        test_add_imm();
        test_mem();
        test_branch();
        test_cond();
        test_unknown();
        test_reset_mid();
        test_random(300);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
